// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, one bit position per clock, start/busy/done handshake.
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, accepted only when busy=0
//   A, shamt        operand and shift amount, sampled on the accepted start edge
//   sel, dir        0/1 = logical/arithmetic, 0/1 = left/right, sampled at start
//   rot             rotate instead of shift (only when SEQ_SHIFTER_ROTATE_EN is defined)
//   busy, done      operation in flight, one-cycle pulse when Aout holds the new result
//   Aout, carry     result register and last bit shifted out
//   zero            Aout == 0
module seq_shifter #(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] shamt,
  input  logic          sel,
  input  logic          dir,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic          rot,
`endif
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Aout,
  output logic          carry,
  output logic          zero
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t st, nxt;
  logic [N-1:0] work, step;
  logic [CW-1:0] cnt, eff;
  logic sel_q, dir_q, rot_q, cry, go, fill, out;
  // done is registered with Aout, so it lands in IDLE; counting it as busy
  // keeps a start in the done cycle from being accepted.
  assign busy = st != IDLE || done;
  assign zero = Aout == '0;
  always_comb begin
    go = start && st == IDLE && !done;
`ifdef SEQ_SHIFTER_ROTATE_EN
    eff = rot ? CW'(32'(shamt) % N) : (32'(shamt) >= N ? CW'(N) : CW'(shamt));
`else
    eff = 32'(shamt) >= N ? CW'(N) : CW'(shamt);
`endif
    fill = dir_q ? (rot_q ? work[0] : sel_q & work[N-1]) : rot_q & work[N-1];
    out  = dir_q ? work[0] : work[N-1];
    step = dir_q ? {fill, work[N-1:1]} : {work[N-2:0], fill};
    nxt  = st == IDLE  ? (go ? (eff != '0 ? SHIFT : FIN) : IDLE) :
           st == SHIFT ? (cnt == CW'(1) ? FIN : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      cnt   <= '0;
      sel_q <= 1'b0;
      dir_q <= 1'b0;
      rot_q <= 1'b0;
      cry   <= 1'b0;
      done  <= 1'b0;
      Aout  <= '0;
      carry <= 1'b0;
    end else begin
      done <= st == FIN;
      if (go) begin
        work  <= A;
        cnt   <= eff;
        sel_q <= sel;
        dir_q <= dir;
`ifdef SEQ_SHIFTER_ROTATE_EN
        rot_q <= rot;
`else
        rot_q <= 1'b0;
`endif
        cry   <= 1'b0;
      end else if (st == SHIFT) begin
        work <= step;
        cnt  <= cnt - CW'(1);
        cry  <= out;
      end else if (st == FIN) begin
        Aout  <= work;
        carry <= cry;
      end
    end
  end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed self-checking bench for seq_shifter.
module tb_seq_shifter;
  localparam int N = 8, SW = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0, dir = 1'b0, rot = 1'b0;
  logic [N-1:0] A = '0;
  logic [SW-1:0] shamt = '0;
  logic busy, done, carry, zero;
  logic [N-1:0] Aout;
  logic [N-1:0] last_exp = '0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  seq_shifter #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .shamt(shamt), .sel(sel), .dir(dir),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rot(rot),
`endif
    .busy(busy), .done(done), .Aout(Aout), .carry(carry), .zero(zero)
  );
  function automatic int eff_of(input logic [SW-1:0] s, input logic r);
    return r ? int'(s) % N : (int'(s) >= N ? N : int'(s));
  endfunction
  // {carry, result} from plain shift/rotate arithmetic
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [SW-1:0] s,
                                       input logic sl, input logic d, input logic r);
    int e;
    logic [N-1:0] res;
    logic c;
    e = eff_of(s, r);
    if (e == 0) return {1'b0, a};
    if (!d) begin
      res = r ? ((a << e) | (a >> (N - e))) : a << e;
      c = a[N-e];
    end else begin
      if (r) res = (a >> e) | (a << (N - e));
      else if (sl) res = $signed(a) >>> e;
      else res = a >> e;
      c = a[e-1];
    end
    return {c, res};
  endfunction
  task automatic issue(input logic [N-1:0] a, input logic [SW-1:0] s, input logic sl,
                       input logic d, input logic r);
    A = a; shamt = s; sel = sl; dir = d; rot = r; start = 1'b1;
  endtask
  task automatic wait_done(output int lat);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %b want 0", done); end
    n_cmp++; if (Aout !== 8'h00) begin n_err++; $display("FAIL reset Aout got %h want 00", Aout); end
    n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset carry got %b want 0", carry); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset zero got %b want 1", zero); end
    rst_n = 1'b1;
  endtask
  task automatic test_left;
    int lat;
    @(negedge clk);
    issue(8'b1001_0110, 3, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL left latency got %0d want 4", lat); end
    n_cmp++; if (Aout !== 8'b1011_0000) begin n_err++; $display("FAIL left Aout got %b want 10110000", Aout); end
    n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL left carry got %b want 0", carry); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL left zero got %b want 0", zero); end
    last_exp = 8'b1011_0000;
  endtask
  task automatic test_right;
    int lat;
    @(negedge clk);
    issue(8'b1000_0100, 2, 1'b1, 1'b1, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rarith latency got %0d want 3", lat); end
    n_cmp++; if (Aout !== 8'b1110_0001) begin n_err++; $display("FAIL rarith Aout got %b want 11100001", Aout); end
    n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL rarith carry got %b want 0", carry); end
    @(negedge clk);
    issue(8'b1000_0100, 2, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    n_cmp++; if (Aout !== 8'b0010_0001) begin n_err++; $display("FAIL rlogic Aout got %b want 00100001", Aout); end
    n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL rlogic carry got %b want 0", carry); end
    last_exp = 8'b0010_0001;
  endtask
  task automatic test_zero_clamp;
    int lat;
    @(negedge clk);
    issue(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL shamt0 latency got %0d want 1", lat); end
    n_cmp++; if (Aout !== 8'h5A) begin n_err++; $display("FAIL shamt0 Aout got %h want 5a", Aout); end
    n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL shamt0 carry got %b want 0", carry); end
    @(negedge clk);
    issue(8'h80, 15, 1'b1, 1'b1, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL clamp latency got %0d want 9", lat); end
    n_cmp++; if (Aout !== 8'hFF) begin n_err++; $display("FAIL clamp Aout got %h want ff", Aout); end
    n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL clamp carry got %b want 1", carry); end
    @(negedge clk);
    issue(8'hC3, 12, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (Aout !== 8'h00) begin n_err++; $display("FAIL clampl Aout got %h want 00", Aout); end
    n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL clampl carry got %b want 1", carry); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL clampl zero got %b want 1", zero); end
    last_exp = 8'h00;
  endtask
  task automatic test_handshake;
    int lat;
    bit seen;
    @(negedge clk);
    issue(8'b1001_0110, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hs busy got %b want 1", busy); end
    issue(8'h0F, 0, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL hs latency got %0d want 3", lat); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hs done-cycle busy got %b want 1", busy); end
    n_cmp++; if (Aout !== 8'hB0) begin n_err++; $display("FAIL hs Aout got %h want b0", Aout); end
    issue(8'h33, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs after-done busy got %b want 0", busy); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL hs ignored-start done got %b want 0", seen); end
    n_cmp++; if (Aout !== 8'hB0) begin n_err++; $display("FAIL hs hold Aout got %h want b0", Aout); end
    issue(8'h33, 1, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    issue(8'h44, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    issue(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL hs reaccept latency got %0d want 1", lat); end
    n_cmp++; if (Aout !== 8'h3C) begin n_err++; $display("FAIL hs reaccept Aout got %h want 3c", Aout); end
    last_exp = 8'h3C;
  endtask
  task automatic test_rotate;
`ifdef SEQ_SHIFTER_ROTATE_EN
    int lat;
    @(negedge clk);
    issue(8'b1000_0001, 9, 1'b1, 1'b0, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rot latency got %0d want 2", lat); end
    n_cmp++; if (Aout !== 8'b0000_0011) begin n_err++; $display("FAIL rot Aout got %b want 00000011", Aout); end
    n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL rot carry got %b want 1", carry); end
    @(negedge clk);
    issue(8'hA7, 8, 1'b0, 1'b1, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rot0 latency got %0d want 1", lat); end
    n_cmp++; if (Aout !== 8'hA7) begin n_err++; $display("FAIL rot0 Aout got %h want a7", Aout); end
    last_exp = 8'hA7;
`endif
  endtask
  task automatic test_random;
    logic [N-1:0] a;
    logic [SW-1:0] s;
    logic sl, d, r;
    logic [N:0] exp;
    int lat, want;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom); s = SW'($urandom); sl = 1'($urandom); d = 1'($urandom);
`ifdef SEQ_SHIFTER_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      exp = model(a, s, sl, d, r);
      want = eff_of(s, r) + 1;
      @(negedge clk);
      issue(a, s, sl, d, r);
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rnd%0d busy got %b want 1", i, busy); end
      n_cmp++; if (Aout !== last_exp) begin n_err++; $display("FAIL rnd%0d stable Aout got %h want %h", i, Aout, last_exp); end
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
        A = N'($urandom); shamt = SW'($urandom); sel = 1'($urandom); dir = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      n_cmp++; if (lat !== want) begin n_err++; $display("FAIL rnd%0d latency got %0d want %0d", i, lat, want); end
      n_cmp++; if (Aout !== exp[N-1:0]) begin n_err++; $display("FAIL rnd%0d Aout got %h want %h (A=%h s=%0d sel=%b dir=%b rot=%b)", i, Aout, exp[N-1:0], a, s, sl, d, r); end
      n_cmp++; if (carry !== exp[N]) begin n_err++; $display("FAIL rnd%0d carry got %b want %b", i, carry, exp[N]); end
      n_cmp++; if (zero !== (exp[N-1:0] == '0)) begin n_err++; $display("FAIL rnd%0d zero got %b", i, zero); end
      last_exp = exp[N-1:0];
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rnd%0d done width got %b want 0", i, done); end
    end
  endtask
  task automatic test_reset_mid;
    int lat;
    bit seen;
    @(negedge clk);
    issue(8'hFF, 5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy got %b want 0", busy); end
    n_cmp++; if (Aout !== 8'h00) begin n_err++; $display("FAIL rstmid Aout got %h want 00", Aout); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL rstmid zero got %b want 1", zero); end
    n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL rstmid carry got %b want 0", carry); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid aborted done got %b want 0", seen); end
    issue(8'h5A, 1, 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    n_cmp++; if (Aout !== 8'hB4) begin n_err++; $display("FAIL rstmid post Aout got %h want b4", Aout); end
  endtask
  initial begin
    test_reset();
    test_left();
    test_right();
    test_zero_clamp();
    test_handshake();
    test_rotate();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
